// File: rtl/bsg_dff_en.sv
// Enable-loaded data register. The contents are not reset: the surrounding
// control never presents storage that has not been written since reset.
module bsg_dff_en #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_r;

  always_ff @(posedge clk_i) begin
    if (en_i) data_r <= data_i;
  end

  assign data_o = data_r;

endmodule

// File: rtl/bsg_two_entry_skid_fifo_ctrl.sv
// Pointer and flag control for the two-entry skid FIFO. ready_o and v_o come
// from registered flags, gated only by reset, so neither depends on yumi_i or v_i.
module bsg_two_entry_skid_fifo_ctrl (
  input  logic clk_i,
  input  logic reset_i,
  input  logic v_i,
  input  logic yumi_i,
  output logic ready_o,
  output logic v_o,
  output logic enq_o,
  output logic wr_ptr_o,
  output logic rd_ptr_o
);

  logic wr_ptr_r, rd_ptr_r;
  logic empty_r, full_r;
  logic enq, deq;

  assign ready_o = ~full_r & ~reset_i;
  assign v_o     = ~empty_r & ~reset_i;

  // Reset gating on ready_o/v_o also makes any enq/deq in a reset cycle a no-op.
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (enq) wr_ptr_r <= ~wr_ptr_r;
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      // Simultaneous enq/deq only happens with one entry held: flags stay put.
      if (enq && !deq) begin
        empty_r <= 1'b0;
        full_r  <= (~wr_ptr_r == rd_ptr_r);
      end else if (deq && !enq) begin
        full_r  <= 1'b0;
        empty_r <= (~rd_ptr_r == wr_ptr_r);
      end
    end
  end

  assign enq_o    = enq;
  assign wr_ptr_o = wr_ptr_r;
  assign rd_ptr_o = rd_ptr_r;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!$isunknown({v_i, yumi_i}));
      assert (!(yumi_i && !v_o));
    end
  end
`endif

endmodule

// File: rtl/bsg_two_entry_skid_fifo.sv
// Two-entry valid/yumi FIFO with registered ready_o/v_o; full throughput with
// no combinational path from the producer side to the consumer side.
module bsg_two_entry_skid_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic enq, wr_ptr, rd_ptr;
  logic [width_p-1:0] mem0, mem1;

  bsg_two_entry_skid_fifo_ctrl ctrl (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .v_i      (v_i),
    .yumi_i   (yumi_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .enq_o    (enq),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr)
  );

  bsg_dff_en #(.width_p(width_p)) mem0_reg (
    .clk_i  (clk_i),
    .en_i   (enq & ~wr_ptr),
    .data_i (data_i),
    .data_o (mem0)
  );

  bsg_dff_en #(.width_p(width_p)) mem1_reg (
    .clk_i  (clk_i),
    .en_i   (enq & wr_ptr),
    .data_i (data_i),
    .data_o (mem1)
  );

  // Head select uses only the registered read pointer.
  assign data_o = rd_ptr ? mem1 : mem0;

endmodule

// File: tb/tb_bsg_two_entry_skid_fifo.sv
// Randomized and directed checks of bsg_two_entry_skid_fifo against a
// queue-based reference model of a two-deep FIFO.
module tb_bsg_two_entry_skid_fifo;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        ready_o, v_o;
  logic [15:0] data_o;
  logic        yumi_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int received = 0;
  logic [15:0] model_q[$];

  always #5 clk = ~clk;

  bsg_two_entry_skid_fifo #(.width_p(16)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev, er;
    ev = !reset_i && (model_q.size() > 0);
    er = !reset_i && (model_q.size() < 2);
    chk("v_o", v_o, ev);
    chk("ready_o", ready_o, er);
    if (ev) chk("data_o", data_o, model_q[0]);
  endtask

  // Apply inputs for one cycle, advance the model at the edge, check at negedge.
  task automatic step(input logic v, input logic [15:0] d, input logic y, input logic r);
    logic do_enq, do_deq;
    v_i = v; data_i = d; yumi_i = y; reset_i = r;
    do_enq = !r && v && (model_q.size() < 2);
    do_deq = !r && y && (model_q.size() > 0);
    @(posedge clk);
    if (r) model_q.delete();
    else begin
      if (do_deq) begin void'(model_q.pop_front()); received++; end
      if (do_enq) model_q.push_back(d);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    // Reset then idle
    @(negedge clk);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0);

    // Single word, held until popped
    step(1'b1, 16'hA5A5, 1'b0, 1'b0);
    chk("single_data", data_o, 16'hA5A5);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("single_empty", v_o, 1'b0);

    // Fill to full; third word must be dropped
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0);
    chk("full_ready", ready_o, 1'b0);
    step(1'b1, 16'h0003, 1'b0, 1'b0);
    chk("pop1", data_o, 16'h0001);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("pop2", data_o, 16'h0002);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drained", v_o, 1'b0);

    // Streaming 1..100 with immediate pops
    received = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1'b1, 16'(k), (model_q.size() > 0), 1'b0);
      chk("stream_ready", ready_o, 1'b1);
    end
    while (model_q.size() > 0) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("stream_count", received, 100);

    // Random backpressure
    for (int c = 0; c < 1000; c++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom),
           (model_q.size() > 0) && 1'($urandom_range(0, 1)), 1'b0);
    end
    while (model_q.size() > 0) step(1'b0, 16'h0, 1'b1, 1'b0);

    // Reset mid-operation with simultaneous v_i/yumi_i
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    chk("pre_reset_full", ready_o, 1'b0);
    step(1'b1, 16'h3333, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("post_reset_v", v_o, 1'b0);
    chk("post_reset_ready", ready_o, 1'b1);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("first_after_reset", data_o, 16'hBEEF);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("final_empty", v_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_two_entry_skid_fifo.md
Name: bsg_two_entry_skid_fifo

Overview:
- Two-entry ready/valid FIFO. It sits on the consumer side of an enable-loaded holding register and drains that data through a valid/yumi handshake.
- The producer loads with v_i while ready_o is high. The consumer sees v_o/data_o and pops with yumi_i.
- Full throughput: one enqueue and one dequeue per cycle, with no combinational path from input to output.

Parameters:
- width_p, 16, data width in bits.

Ports:
- clk_i  input  1  clock; all state updates on the posedge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  1  producer data valid; enqueue occurs when v_i & ready_o.
- data_i  input  width_p  producer data.
- ready_o  output  1  FIFO can accept data this cycle; registered, equals ~full.
- v_o  output  1  head entry is valid; registered, equals ~empty.
- data_o  output  width_p  head-entry data; undefined when v_o=0.
- yumi_i  input  1  consumer pops the head this cycle; legal only when v_o=1.

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high.
- State:
  - mem[0:1] of width_p bits.
  - wr_ptr_r and rd_ptr_r, 1 bit each.
  - empty_r and full_r flags.
- Reset (reset_i high at a posedge):
  - wr_ptr_r=0, rd_ptr_r=0, empty_r=1, full_r=0.
  - mem is not reset.
  - While reset_i is high, v_o=0 and ready_o=0 (both gated). On the first cycle after deassertion, v_o=0 and ready_o=1.
  - Reset mid-operation discards all stored entries. Any enq/deq in the reset cycle is ignored.
- Derived signals:
  - enq = v_i & ready_o.
  - deq = yumi_i & v_o.
- Enqueue:
  - mem[wr_ptr_r] <= data_i.
  - wr_ptr_r toggles.
- Dequeue:
  - rd_ptr_r toggles.
  - data_o = mem[rd_ptr_r], a mux on the registered pointer only.
- Flag update:
  - enq & ~deq: empty_r<=0; full_r<=(wr_ptr_r+1==rd_ptr_r).
  - deq & ~enq: full_r<=0; empty_r<=(rd_ptr_r+1==wr_ptr_r).
  - enq & deq: flags unchanged, both pointers toggle. This is only possible with exactly one entry, since full blocks enq and empty blocks deq.
  - Neither: hold.
- Latency:
  - Data enqueued at edge N is visible at v_o/data_o after edge N; minimum one-cycle fall-through.
  - No bypass when empty.
- Full boundary: ready_o=0.
  - A v_i asserted while full is dropped; the producer must hold it.
  - A deq in a full cycle makes ready_o=1 in the next cycle. ready_o never depends combinationally on yumi_i.
- Empty boundary: v_o=0.
  - yumi_i while v_o=0 is a protocol violation. It has no state effect and fires a simulation assertion.
- Pointer wrap: the 1-bit pointers wrap naturally. Order is strict FIFO.
- data_o holds its value while v_o=1 and no deq occurs.

Decomposition:
- No shared package needed. Only width_p is configurable, and the pointer width is fixed at 1.
- Sub-module: bsg_two_entry_skid_fifo_ctrl holds the pointers, flags, and enq/deq logic.
- Storage is two bsg_dff_en instances with en = enq & (wr_ptr_r==i).
- Assertions (yumi without v_o, and X on control inputs after reset) live in a translate_off block.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset_i=1 for 2 cycles, then release.
  - Required: v_o=0 and ready_o=0 during reset. On the first cycle after release, v_o=0 and ready_o=1, and they stay there with no inputs.
- Single word:
  - Stimulus: v_i=1, data_i=16'hA5A5 for one cycle.
  - Required: next cycle v_o=1 and data_o=16'hA5A5. It holds until yumi_i=1, after which v_o=0.
- Fill to full:
  - Stimulus: enqueue 16'h0001 and 16'h0002 on consecutive cycles with yumi_i=0, then present v_i=1 with 16'h0003.
  - Required: ready_o=0 after the second enqueue and 16'h0003 is not stored. Popping returns 0001 then 0002, after which v_o=0.
- Streaming:
  - Stimulus: v_i=1 with data 1..100 every cycle, yumi_i=v_o every cycle.
  - Required: ready_o stays 1 throughout, outputs arrive in order with one cycle of latency, and 100 words are received with none dropped.
- Random backpressure:
  - Stimulus: 1000 cycles of random v_i and yumi_i (yumi only when v_o=1).
  - Required: the scoreboard matches exact in-order data, and there is never more than 2 outstanding entries.
- Reset mid-operation:
  - Stimulus: fill to full, then assert reset_i for one cycle together with v_i=1 and yumi_i=1.
  - Required: after reset v_o=0 and ready_o=1, no stale data appears, and the next enqueue (16'hBEEF) is the first word out.
